dino_jump_input: RTL and testbench

Input-conditioning stage that sits directly upstream of the game CPU's button-press register (r20). It merges the physical `jump` push-button and the PS/2 keyboard's Space / Up-Arrow keys into one per-frame jump request. The button is synchronised and debounced, and the keyboard byte stream is decoded. Press events are latched and presented once per frame, aligned to the VGA controller's end-of-screen strobe, so the CPU's jump loop reads a stable value for a whole frame.

---
 rtl/dino_jump_input.sv | 174 +++++++++++++++++
 tb/tb_dino_jump_input.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_jump_input.sv
// dino_jump_input
// Merges the physical jump button and the PS/2 Space / Up-Arrow keys into one
// jump request per video frame for the game CPU's button-press register.
//
// Ports:
//   clk          system clock (100 MHz)
//   reset        asynchronous reset, active low
//   jump         raw push-button, asynchronous, active high
//   rx_data      PS/2 byte, qualified by rx_valid
//   rx_valid     one-cycle strobe for rx_data
//   screen_end   end-of-frame level from the VGA controller
//   button_press per-frame jump request, changes only at a frame boundary
//   jump_level   registered OR of debounced button and key-held flag
//
// Keyboard decoder states:
//   state      | meaning
//   ST_IDLE    | waiting for a make code or a prefix byte
//   ST_EXT     | 0xE0 seen, next byte is an extended code
//   ST_BRK     | 0xF0 seen, next byte is a released normal key
//   ST_EXT_BRK | 0xE0 0xF0 seen, next byte is a released extended key
module dino_jump_input #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       jump,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       screen_end,
    output logic       button_press,
    output logic       jump_level
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;

    // ---------------- button synchroniser and debounce ----------------
    logic             sync_1;
    logic             btn_s;
    logic             btn_db;
    logic [CNT_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_1 <= jump;
            btn_s  <= sync_1;
        end
    end

    // The counter only runs while the synchronised level disagrees with the
    // debounced one, so any bounce back restarts the stability window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // ---------------- keyboard scancode decoder ----------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kb_state_t;

    kb_state_t state;
    kb_state_t state_nxt;
    logic      key_dn;
    logic      key_set;
    logic      key_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            key_dn <= 1'b0;
        end else begin
            state <= state_nxt;
            if (key_set) begin
                key_dn <= 1'b1;
            end else if (key_clr) begin
                key_dn <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == PFX_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (rx_data == PFX_BRK) begin
                        state_nxt = ST_BRK;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    state_nxt = (rx_data == PFX_BRK) ? ST_EXT_BRK : ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Space and Up share one held flag; releasing either one clears it.
    always_comb begin
        key_set = 1'b0;
        key_clr = 1'b0;
        if (rx_valid) begin
            case (state)
                ST_IDLE:    key_set = (rx_data == KEY_SPACE);
                ST_EXT:     key_set = (rx_data == KEY_UP);
                ST_BRK:     key_clr = (rx_data == KEY_SPACE);
                ST_EXT_BRK: key_clr = (rx_data == KEY_UP);
                default:    key_set = 1'b0;
            endcase
        end
    end

    // ---------------- press detection and frame latch ----------------
    logic jump_level_q;
    logic press_evt;
    logic fe_q;
    logic frame_tick;
    logic pending;

    assign press_evt  = jump_level & ~jump_level_q;
    assign frame_tick = screen_end & ~fe_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jump_level   <= 1'b0;
            jump_level_q <= 1'b0;
            fe_q         <= 1'b0;
        end else begin
            jump_level   <= btn_db | key_dn;
            jump_level_q <= jump_level;
            fe_q         <= screen_end;
        end
    end

    // A press on the tick edge itself goes straight into the new frame's
    // request rather than into pending, so it is neither lost nor delayed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending      <= 1'b0;
            button_press <= 1'b0;
        end else if (frame_tick) begin
            button_press <= pending | press_evt;
            pending      <= 1'b0;
        end else begin
            pending      <= pending | press_evt;
        end
    end

endmodule

// File: tb/tb_dino_jump_input.sv
module tb_dino_jump_input;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       jump = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       screen_end = 1'b0;
    logic       button_press;
    logic       jump_level;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        string tag;
        logic  val;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dino_jump_input #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .jump         (jump),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .screen_end   (screen_end),
        .button_press (button_press),
        .jump_level   (jump_level)
    );

    task automatic check_val(input string tag, input logic obs, input logic exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b want=%b", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL scoreboard_empty: got=%b want=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic frame();
        screen_end = 1'b1;
        @(negedge clk);
        screen_end = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;

        // reset state
        cyc(2);
        push_exp("rst_button_press", 1'b0);
        pop_check(button_press);
        push_exp("rst_jump_level", 1'b0);
        pop_check(jump_level);
        reset = 1'b1;
        cyc(2);

        // 1: reset mid-operation (key held, pending set, FSM in EXT, button high)
        put(8'h29);
        cyc(3);
        push_exp("t1_pre_jump_level", 1'b1);
        pop_check(jump_level);
        put(8'hE0);
        jump = 1'b1;
        cyc(1);
        reset = 1'b0;
        #1;
        push_exp("t1_rst_button_press", 1'b0);
        pop_check(button_press);
        push_exp("t1_rst_jump_level", 1'b0);
        pop_check(jump_level);
        cyc(3);
        reset = 1'b1;
        jump  = 1'b0;
        put(8'h75);
        cyc(2);
        push_exp("t1_75_from_idle", 1'b0);
        pop_check(jump_level);
        frame();
        push_exp("t1_pending_cleared", 1'b0);
        pop_check(button_press);

        // 2: debounce
        jump = 1'b1;
        cyc(3);
        jump = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | jump_level;
        end
        push_exp("t2_glitch_ignored", 1'b0);
        pop_check(seen);
        jump = 1'b1;
        cyc(6);
        push_exp("t2_before_latency", 1'b0);
        pop_check(jump_level);
        cyc(1);
        push_exp("t2_at_latency", 1'b1);
        pop_check(jump_level);
        cyc(3);
        jump = 1'b0;
        cyc(8);
        push_exp("t2_released", 1'b0);
        pop_check(jump_level);

        // 3: keyboard decode (jump_level follows key_dn one cycle later)
        put(8'h29);
        cyc(1);
        push_exp("t3_space_make", 1'b1);
        pop_check(jump_level);
        put(8'h1C);
        put(8'hF0);
        put(8'h1C);
        cyc(1);
        push_exp("t3_other_keys_hold", 1'b1);
        pop_check(jump_level);
        put(8'hF0);
        put(8'h29);
        cyc(1);
        push_exp("t3_space_break", 1'b0);
        pop_check(jump_level);
        put(8'hE0);
        put(8'h29);
        cyc(1);
        push_exp("t3_ext_other_to_idle", 1'b0);
        pop_check(jump_level);
        put(8'hE0);
        put(8'h75);
        cyc(1);
        push_exp("t3_up_make", 1'b1);
        pop_check(jump_level);
        put(8'hE0);
        put(8'hF0);
        put(8'h75);
        cyc(1);
        push_exp("t3_up_break", 1'b0);
        pop_check(jump_level);
        put(8'h1C);
        cyc(1);
        push_exp("t3_1c_no_change", 1'b0);
        pop_check(jump_level);

        // 4: frame latching, two presses collapse to one request
        frame();
        frame();
        push_exp("t4_flushed", 1'b0);
        pop_check(button_press);
        for (int k = 0; k < 2; k++) begin
            put(8'h29);
            cyc(2);
            put(8'hF0);
            put(8'h29);
            cyc(3);
        end
        push_exp("t4_held_until_frame", 1'b0);
        pop_check(button_press);
        frame();
        push_exp("t4_request", 1'b1);
        pop_check(button_press);
        cyc(5);
        push_exp("t4_stable_in_frame", 1'b1);
        pop_check(button_press);
        frame();
        push_exp("t4_next_frame_clear", 1'b0);
        pop_check(button_press);

        // 5: press_evt on the same edge as the screen_end rise
        put(8'h29);
        cyc(1);
        screen_end = 1'b1;
        cyc(1);
        screen_end = 1'b0;
        push_exp("t5_same_edge", 1'b1);
        pop_check(button_press);
        put(8'hF0);
        put(8'h29);
        cyc(3);
        frame();
        push_exp("t5_pending_zero", 1'b0);
        pop_check(button_press);

        // 6: long screen_end with a press in the middle
        screen_end = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            rx_valid = 1'b0;
            if (i == 20) begin
                rx_data  = 8'h29;
                rx_valid = 1'b1;
            end else if (i == 25) begin
                rx_data  = 8'hF0;
                rx_valid = 1'b1;
            end else if (i == 26) begin
                rx_data  = 8'h29;
                rx_valid = 1'b1;
            end
            @(negedge clk);
            seen = seen | button_press;
        end
        rx_valid   = 1'b0;
        screen_end = 1'b0;
        push_exp("t6_no_update_high", 1'b0);
        pop_check(seen);
        cyc(3);
        push_exp("t6_still_zero", 1'b0);
        pop_check(button_press);
        frame();
        push_exp("t6_next_rise", 1'b1);
        pop_check(button_press);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
